// File: rtl/ice_bus_arb.sv
// Round-robin arbiter bridging host and monitor ports onto the ICE register bus.
// Optional macro ICEARB_USRPROT_EN blocks user-mode monitor writes to 0880_4000h.
module ice_bus_arb #(
    parameter int unsigned WR_LOW_CYC  = 2,
    parameter int unsigned RD_WAIT_CYC = 2
) (
    input  logic        ICECK,
    input  logic        ICERES,
    input  logic        HREQ,
    input  logic        HWR,
    input  logic [31:0] HADR,
    input  logic [31:0] HWDT,
    output logic        HACK,
    output logic [31:0] HRDT,
    output logic        HERR,
    input  logic        MREQ,
    input  logic        MWR,
    input  logic [31:0] MADR,
    input  logic [31:0] MWDT,
    output logic        MACK,
    output logic [31:0] MRDT,
    output logic        MERR,
    input  logic        SVMODUSER,
    output logic [31:0] ICEIFA,
    output logic [31:0] ICEDI,
    input  logic [31:0] ICEDO,
    output logic        ICEWR
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam logic [DW-1:0] ADR_MASK = 32'hFFFF_FFFC;
    localparam logic [DW-1:0] PROT_ADR = 32'h0880_4000;
    localparam logic [CW-1:0] WR_LOAD  = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] RD_LOAD  = CW'(RD_WAIT_CYC - 1);
`ifdef ICEARB_USRPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, READ, HOLD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            gnt_mon, gnt_mon_nxt;
    logic            last_mon, last_mon_nxt;
    logic            wr_q, wr_nxt;
    logic            blk_q, blk_nxt;
    logic [DW-1:0]   adr_q, adr_nxt;
    logic [DW-1:0]   wdt_q, wdt_nxt;
    logic            hack_nxt, mack_nxt, merr_nxt, icewr_nxt;
    logic [DW-1:0]   hrdt_nxt, mrdt_nxt, iceifa_nxt, icedi_nxt;
    logic            sel;

    assign HERR = 1'b0;

    // Next-state, transaction latch and registered-output next values
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        gnt_mon_nxt  = gnt_mon;
        last_mon_nxt = last_mon;
        wr_nxt       = wr_q;
        blk_nxt      = blk_q;
        adr_nxt      = adr_q;
        wdt_nxt      = wdt_q;
        hack_nxt     = 1'b0;
        mack_nxt     = 1'b0;
        merr_nxt     = 1'b0;
        hrdt_nxt     = HRDT;
        mrdt_nxt     = MRDT;
        sel          = 1'b0;

        case (state)
            IDLE: begin
                if (HREQ || MREQ) begin
                    sel          = (HREQ && MREQ) ? !last_mon : MREQ;
                    gnt_mon_nxt  = sel;
                    last_mon_nxt = sel;
                    wr_nxt       = sel ? MWR : HWR;
                    adr_nxt      = (sel ? MADR : HADR) & ADR_MASK;
                    wdt_nxt      = sel ? MWDT : HWDT;
                    blk_nxt      = PROT_EN && sel && MWR && SVMODUSER
                                   && ((MADR & ADR_MASK) == PROT_ADR);
                    cnt_nxt      = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                cnt_nxt   = wr_q ? WR_LOAD : RD_LOAD;
                state_nxt = wr_q ? STROBE : READ;
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            READ: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    if (gnt_mon) mrdt_nxt = ICEDO;
                    else         hrdt_nxt = ICEDO;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            HOLD: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
                hack_nxt  = !gnt_mon;
                mack_nxt  = gnt_mon;
                merr_nxt  = gnt_mon && blk_q;
            end
            default: state_nxt = IDLE;
        endcase

        // Bus outputs follow the state being entered so they align with it
        iceifa_nxt = '0;
        icedi_nxt  = '0;
        icewr_nxt  = 1'b1;
        if (state_nxt != IDLE) begin
            iceifa_nxt = adr_nxt;
            icedi_nxt  = wr_nxt ? wdt_nxt : '0;
            icewr_nxt  = !((state_nxt == STROBE) && !blk_nxt);
        end
    end

    always_ff @(posedge ICECK) begin
        if (ICERES) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt_mon  <= 1'b0;
            last_mon <= 1'b1;
            wr_q     <= 1'b0;
            blk_q    <= 1'b0;
            adr_q    <= '0;
            wdt_q    <= '0;
            HACK     <= 1'b0;
            MACK     <= 1'b0;
            MERR     <= 1'b0;
            HRDT     <= '0;
            MRDT     <= '0;
            ICEIFA   <= '0;
            ICEDI    <= '0;
            ICEWR    <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            gnt_mon  <= gnt_mon_nxt;
            last_mon <= last_mon_nxt;
            wr_q     <= wr_nxt;
            blk_q    <= blk_nxt;
            adr_q    <= adr_nxt;
            wdt_q    <= wdt_nxt;
            HACK     <= hack_nxt;
            MACK     <= mack_nxt;
            MERR     <= merr_nxt;
            HRDT     <= hrdt_nxt;
            MRDT     <= mrdt_nxt;
            ICEIFA   <= iceifa_nxt;
            ICEDI    <= icedi_nxt;
            ICEWR    <= icewr_nxt;
        end
    end

endmodule

// File: tb/tb_ice_bus_arb.sv
// Directed self-checking bench for ice_bus_arb (default WR_LOW_CYC = RD_WAIT_CYC = 2).
// Cycle k = number of rising edges since the grant edge, sampled on the falling edge.
module tb_ice_bus_arb;

    logic        ICECK = 1'b0;
    logic        ICERES, HREQ, HWR, MREQ, MWR, SVMODUSER;
    logic [31:0] HADR, HWDT, MADR, MWDT, ICEDO;
    logic        HACK, HERR, MACK, MERR, ICEWR;
    logic [31:0] HRDT, MRDT, ICEIFA, ICEDI;

    int checks = 0;
    int errors = 0;

`ifdef ICEARB_USRPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    ice_bus_arb #(.WR_LOW_CYC(2), .RD_WAIT_CYC(2)) dut (
        .ICECK(ICECK), .ICERES(ICERES),
        .HREQ(HREQ), .HWR(HWR), .HADR(HADR), .HWDT(HWDT),
        .HACK(HACK), .HRDT(HRDT), .HERR(HERR),
        .MREQ(MREQ), .MWR(MWR), .MADR(MADR), .MWDT(MWDT),
        .MACK(MACK), .MRDT(MRDT), .MERR(MERR),
        .SVMODUSER(SVMODUSER),
        .ICEIFA(ICEIFA), .ICEDI(ICEDI), .ICEDO(ICEDO), .ICEWR(ICEWR)
    );

    always #5 ICECK = ~ICECK;

    task automatic step();
        @(negedge ICECK);
    endtask

    task automatic test_reset();
        ICERES = 1'b1;
        step(); step();
        checks++; if (ICEWR !== 1'b1) begin errors++; $display("FAIL reset_icewr got=%b exp=1", ICEWR); end
        checks++; if (ICEIFA !== 32'h0 || ICEDI !== 32'h0) begin errors++; $display("FAIL reset_bus got=%h/%h exp=0/0", ICEIFA, ICEDI); end
        checks++; if ({HACK, MACK, HERR, MERR} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {HACK, MACK, HERR, MERR}); end
        checks++; if (HRDT !== 32'h0 || MRDT !== 32'h0) begin errors++; $display("FAIL reset_rdt got=%h/%h exp=0/0", HRDT, MRDT); end
        ICERES = 1'b0;
        step();
        checks++; if (ICEWR !== 1'b1 || ICEIFA !== 32'h0) begin errors++; $display("FAIL idle_after_reset got=%b/%h exp=1/0", ICEWR, ICEIFA); end
    endtask

    task automatic test_host_write();
        int lows = 0;
        HWR = 1'b1; HADR = 32'h0880_4000; HWDT = 32'h0000_03FF; HREQ = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (ICEWR === 1'b0) lows++;
            if (k <= 4) begin
                checks++; if (ICEIFA !== 32'h0880_4000 || ICEDI !== 32'h0000_03FF) begin errors++; $display("FAIL hw_bus k=%0d got=%h/%h exp=08804000/000003ff", k, ICEIFA, ICEDI); end
                checks++; if (ICEWR !== ((k == 2 || k == 3) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL hw_strobe k=%0d got=%b", k, ICEWR); end
            end
            checks++; if (HACK !== (k == 5)) begin errors++; $display("FAIL hw_ack k=%0d got=%b exp=%b", k, HACK, k == 5); end
            if (k == 5) begin
                checks++; if (ICEIFA !== 32'h0 || ICEDI !== 32'h0 || HERR !== 1'b0 || HRDT !== 32'h0) begin errors++; $display("FAIL hw_done got=%h/%h/%b/%h exp=0/0/0/0", ICEIFA, ICEDI, HERR, HRDT); end
                HREQ = 1'b0;
            end
        end
        checks++; if (lows != 2) begin errors++; $display("FAIL hw_low_cycles got=%0d exp=2", lows); end
    endtask

    task automatic test_mon_read();
        MWR = 1'b0; MADR = 32'h0880_4000; ICEDO = 32'h0000_02DD; MREQ = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin
                checks++; if (ICEIFA !== 32'h0880_4000 || ICEDI !== 32'h0 || ICEWR !== 1'b1) begin errors++; $display("FAIL mr_setup got=%h/%h/%b", ICEIFA, ICEDI, ICEWR); end
            end
            if (k == 3) begin
                checks++; if (MRDT !== 32'h0) begin errors++; $display("FAIL mr_early_load got=%h exp=0", MRDT); end
            end
            checks++; if (MACK !== (k == 5) || HACK !== 1'b0) begin errors++; $display("FAIL mr_ack k=%0d got=%b/%b", k, MACK, HACK); end
            if (k == 5) begin
                checks++; if (MRDT !== 32'h0000_02DD || MERR !== 1'b0) begin errors++; $display("FAIL mr_data got=%h/%b exp=000002dd/0", MRDT, MERR); end
                MREQ = 1'b0; ICEDO = 32'hDEAD_BEEF;
            end
        end
        checks++; if (MRDT !== 32'h0000_02DD || HRDT !== 32'h0) begin errors++; $display("FAIL mr_hold got=%h/%h exp=000002dd/0", MRDT, HRDT); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_adr;
        ICERES = 1'b1; step(); ICERES = 1'b0;
        HWR = 1'b0; MWR = 1'b0; HADR = 32'h0000_1000; MADR = 32'h0000_2000; ICEDO = 32'h0000_0055;
        HREQ = 1'b1; MREQ = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_adr = (((k - 1) / 5) % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
            if (k % 5 == 1) begin
                checks++; if (ICEIFA !== exp_adr) begin errors++; $display("FAIL rr_grant k=%0d got=%h exp=%h", k, ICEIFA, exp_adr); end
            end
            if (k % 5 == 0) begin
                checks++; if (HACK !== (exp_adr == 32'h0000_1000) || MACK !== (exp_adr == 32'h0000_2000) || ICEIFA !== 32'h0) begin errors++; $display("FAIL rr_ack k=%0d got=%b/%b/%h", k, HACK, MACK, ICEIFA); end
            end
        end
        HREQ = 1'b0; MREQ = 1'b0;
        step();
        checks++; if (HRDT !== 32'h0000_0055 || MRDT !== 32'h0000_0055) begin errors++; $display("FAIL rr_rdt got=%h/%h exp=55/55", HRDT, MRDT); end
    endtask

    task automatic test_usr_prot();
        int lows;
        SVMODUSER = 1'b1;
        MWR = 1'b1; MADR = 32'h0880_4000; MWDT = 32'h0000_0012; MREQ = 1'b1;
        lows = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (ICEWR === 1'b0) lows++;
            if (k == 5) begin
                checks++; if (MACK !== 1'b1 || MERR !== PROT) begin errors++; $display("FAIL prot_mon_ack got=%b/%b exp=1/%b", MACK, MERR, PROT); end
                MREQ = 1'b0;
            end
        end
        checks++; if (lows != (PROT ? 0 : 2)) begin errors++; $display("FAIL prot_mon_low got=%0d exp=%0d", lows, PROT ? 0 : 2); end
        HWR = 1'b1; HADR = 32'h0880_4000; HWDT = 32'h0000_0034; HREQ = 1'b1;
        lows = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (ICEWR === 1'b0) lows++;
            if (k == 5) begin
                checks++; if (HACK !== 1'b1 || HERR !== 1'b0) begin errors++; $display("FAIL prot_host_ack got=%b/%b exp=1/0", HACK, HERR); end
                HREQ = 1'b0;
            end
        end
        checks++; if (lows != 2) begin errors++; $display("FAIL prot_host_low got=%0d exp=2", lows); end
        SVMODUSER = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        HWR = 1'b1; HADR = 32'h0000_0040; HWDT = 32'h0000_00AA; HREQ = 1'b1;
        step(); step();
        checks++; if (ICEWR !== 1'b0) begin errors++; $display("FAIL rm_in_strobe got=%b exp=0", ICEWR); end
        ICERES = 1'b1; HREQ = 1'b0;
        step();
        ICERES = 1'b0;
        checks++; if (ICEWR !== 1'b1 || ICEIFA !== 32'h0 || HACK !== 1'b0) begin errors++; $display("FAIL rm_abort got=%b/%h/%b exp=1/0/0", ICEWR, ICEIFA, HACK); end
        for (int k = 0; k < 6; k++) begin
            step();
            if (HACK === 1'b1) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL rm_no_ack got=%0d exp=0", acks); end
        HREQ = 1'b1; acks = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin
                checks++; if (ICEIFA !== 32'h0000_0040) begin errors++; $display("FAIL rm_regrant got=%h exp=00000040", ICEIFA); end
            end
            if (HACK === 1'b1) begin acks++; HREQ = 1'b0; end
            if (k == 5) begin
                checks++; if (HACK !== 1'b1) begin errors++; $display("FAIL rm_service got=%b exp=1", HACK); end
            end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL rm_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_req_drop();
        int acks = 0;
        HWR = 1'b0; HADR = 32'h0000_0107; ICEDO = 32'h0000_7777; HREQ = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                checks++; if (ICEIFA !== 32'h0000_0104) begin errors++; $display("FAIL rd_align got=%h exp=00000104", ICEIFA); end
                HREQ = 1'b0;
            end
            if (HACK === 1'b1) acks++;
            if (k == 5) begin
                checks++; if (HACK !== 1'b1 || HRDT !== 32'h0000_7777) begin errors++; $display("FAIL rd_complete got=%b/%h exp=1/00007777", HACK, HRDT); end
            end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL rd_ack_count got=%0d exp=1", acks); end
    endtask

    initial begin
        ICERES = 1'b1; HREQ = 1'b0; HWR = 1'b0; HADR = '0; HWDT = '0;
        MREQ = 1'b0; MWR = 1'b0; MADR = '0; MWDT = '0; SVMODUSER = 1'b0; ICEDO = '0;
        test_reset();
        test_host_write();
        test_mon_read();
        test_round_robin();
        test_usr_prot();
        test_reset_mid();
        test_req_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ice_bus_arb.md
ICE_BUS_ARB -- requirements
Module: ice_bus_arb

Interface
REQ-001 Parameter WR_LOW_CYC, default 2: number of cycles ICEWR is held low per write (legal 1..15).
REQ-002 Parameter RD_WAIT_CYC, default 2: number of cycles from address valid to ICEDO capture (legal 1..15).
REQ-003 ICECK  in  1  single clock, all state changes on the rising edge.
REQ-004 ICERES  in  1  reset, synchronous and active-high.
REQ-005 HREQ / MREQ  in  1  transaction request from the host and monitor ports; held until the matching ACK.
REQ-006 HWR / MWR  in  1  1 = write, 0 = read; sampled at grant.
REQ-007 HADR / MADR  in  32  byte address; sampled at grant.
REQ-008 HWDT / MWDT  in  32  write data; sampled at grant.
REQ-009 HACK / MACK  out  1  one-cycle completion pulse per port.
REQ-010 HRDT / MRDT  out  32  read data per port.
REQ-011 HERR / MERR  out  1  protection-blocked flag, valid with ACK.
REQ-012 SVMODUSER  in  1  supervisor user-mode indicator.
REQ-013 ICEIFA  out  32  ICE register bus address.
REQ-014 ICEDI  out  32  ICE register bus write data.
REQ-015 ICEDO  in  32  ICE register bus read data (OR of slave outputs).
REQ-016 ICEWR  out  1  write strobe, active low; slaves latch on its falling edge.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, STROBE, READ and HOLD.
REQ-018 In IDLE with any request pending, the block SHALL grant one port, latch its WR/ADR/WDT, and move to SETUP.
REQ-019 Arbitration SHALL be round-robin: when both ports request, the port not granted last wins; a lone requester always wins.
REQ-020 SETUP SHALL last 1 cycle, driving ICEIFA = {ADR[31:2],2'b00}, ICEDI = WDT for writes and 0 for reads, and ICEWR = 1.
REQ-021 After SETUP, a write SHALL enter STROBE for WR_LOW_CYC cycles with ICEWR = 0; ICEIFA and ICEDI SHALL remain stable.
REQ-022 After SETUP, a read SHALL enter READ for RD_WAIT_CYC cycles; at the last READ edge the granted port's RDT SHALL load ICEDO.
REQ-023 HOLD SHALL last 1 cycle with ICEWR = 1 and address/data unchanged, and SHALL pulse the granted port's ACK; the FSM then returns to IDLE.
REQ-024 Latency from the grant edge to ACK high SHALL be 2+WR_LOW_CYC cycles for a write and 2+RD_WAIT_CYC cycles for a read; requests are sampled only in IDLE.
REQ-025 In IDLE, ICEIFA = 0, ICEDI = 0 and ICEWR = 1.
REQ-026 RDT SHALL hold its value until the next read completes on the same port; writes SHALL leave RDT unchanged.
REQ-027 A request that drops after grant SHALL NOT abort the transaction; ACK is still pulsed.
REQ-028 The internal cycle counter SHALL be 4 bits and reload on each state entry; it SHALL never wrap within a state.

Reset
REQ-029 With ICERES high at an edge: FSM = IDLE, ICEWR = 1, ICEIFA = ICEDI = 0, ACK = ERR = 0, RDT = 0, and the round-robin pointer set so the host wins the first tie.
REQ-030 Reset asserted mid-transaction SHALL abort it at that edge with no ACK; if the FSM was in STROBE, ICEWR returns high and the slave latch completes.

Configuration
REQ-031 Macro ICEARB_USRPROT_EN: when defined, a monitor-port write to word address 0880_4000h while SVMODUSER = 1 (sampled at grant) SHALL run the full FSM timing with ICEWR held 1 throughout, and SHALL pulse MACK with MERR = 1.
REQ-032 When ICEARB_USRPROT_EN is undefined, no protection applies, HERR = MERR = 0 constantly, and all writes strobe ICEWR; HERR is 0 in both builds.

Verification
REQ-033 Host write to 0880_4000h with data 0000_03FFh, WR_LOW_CYC = 2 -> SETUP 1 cycle, ICEWR low for exactly 2 cycles with stable address/data, HACK high 4 cycles after the grant edge.
REQ-034 Monitor read of 0880_4000h with ICEDO driven to 0000_02DDh, RD_WAIT_CYC = 2 -> MRDT = 0000_02DDh when MACK pulses, 4 cycles after the grant edge.
REQ-035 HREQ and MREQ asserted together continuously for 4 transactions -> grant order host, monitor, host, monitor, with one IDLE cycle between transactions.
REQ-036 ICEARB_USRPROT_EN defined, SVMODUSER = 1, monitor write to 0880_4000h -> ICEWR never low, MACK with MERR = 1; the same access by the host -> normal strobe, HERR = 0.
REQ-037 ICERES pulsed during STROBE -> ICEWR = 1 and FSM in IDLE on the next cycle, no ACK; a following HREQ is serviced normally.
REQ-038 HREQ dropped one cycle after grant -> transaction completes and HACK pulses once.
